// File: rtl/rptr_empty.sv
// Read-domain pointer/status for the async FIFO: read pointer (binary + Gray),
// empty / almost-empty / fill level derived from the synchronized write pointer, sticky underflow.
module rptr_empty #(
  parameter int ADDR_SIZE     = 6,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_inc,
  input  logic [ADDR_SIZE:0]   syn_wptr,
  input  logic                 r_underflow_clr,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 r_empty,
  output logic                 r_aempty,
  output logic [ADDR_SIZE:0]   r_level,
  output logic                 r_underflow
);

  localparam logic [ADDR_SIZE:0] THRESH = AEMPTY_THRESH[ADDR_SIZE:0];

  logic [ADDR_SIZE:0] rbin, rbin_next, rgray_next, wbin, level_next;
  logic               rd_en;

  assign rd_en      = r_inc & ~r_empty;
  assign rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, rd_en};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  genvar i;
  generate
    for (i = 0; i <= ADDR_SIZE; i++) begin : g_g2b
      assign wbin[i] = ^syn_wptr[ADDR_SIZE:i];
    end
  endgenerate

  assign level_next = wbin - rbin_next;
  assign raddr      = rbin[ADDR_SIZE-1:0];

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rbin        <= '0;
      rptr        <= '0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_level     <= '0;
      r_underflow <= 1'b0;
    end else begin
      rbin     <= rbin_next;
      rptr     <= rgray_next;
      // Compare against the post-read pointer so empty asserts on the draining edge.
      r_empty  <= (rgray_next == syn_wptr);
      r_level  <= level_next;
      r_aempty <= (level_next <= THRESH);
      if (r_inc & r_empty)
        r_underflow <= 1'b1;
      else if (r_underflow_clr)
        r_underflow <= 1'b0;
    end
  end

endmodule
